// File: rtl/nios_sd_loader_gpio_pio_pkg.sv
// Shared constants for the GPIO PIO: Avalon register map, edge-capture modes
// and the warm-up counter helper.
package nios_sd_loader_gpio_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_NONE = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_FALL = 2;
    localparam int EDGE_ANY  = 3;

    localparam logic [1:0] WARM_DONE = 2'd3;

    // Saturating increment used to hold off capture for the first clocks after reset.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == WARM_DONE) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/nios_sd_loader_pio_edge_sync.sv
// Two-flop synchroniser plus one history stage per pin, and the edge detector
// selected by EDGE_TYPE.
module nios_sd_loader_pio_edge_sync
    import nios_sd_loader_gpio_pio_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_TYPE  = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic [DATA_WIDTH-1:0] in_sync_o,
    output logic [DATA_WIDTH-1:0] edge_o
);

    logic [DATA_WIDTH-1:0] sync1_q;
    logic [DATA_WIDTH-1:0] sync2_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] rise_s;
    logic [DATA_WIDTH-1:0] fall_s;

    // Pin synchroniser chain; prev_q holds the previous synchronised value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_s    = sync2_q & ~prev_q;
    assign fall_s    = ~sync2_q & prev_q;
    assign in_sync_o = sync2_q;

    // Edge polarity selection; unknown modes disable capture.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: edge_o = rise_s;
            EDGE_FALL: edge_o = fall_s;
            EDGE_ANY:  edge_o = rise_s | fall_s;
            default:   edge_o = '0;
        endcase
    end

endmodule

// File: rtl/nios_sd_loader_gpio_pio.sv
// Avalon-MM GPIO slave: data/direction/mask registers, atomic set/clear,
// edge capture with W1C and a level interrupt; zero-wait-state reads.
module nios_sd_loader_gpio_pio
    import nios_sd_loader_gpio_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '0,
    parameter int                    EDGE_TYPE   = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] dir_q, dir_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [1:0]            warm_cnt_q, warm_cnt_d;

    logic                  wr_s;
    logic                  warm_s;
    logic [DATA_WIDTH-1:0] wd_s;
    logic [DATA_WIDTH-1:0] w1c_s;
    logic [DATA_WIDTH-1:0] in_sync_s;
    logic [DATA_WIDTH-1:0] edge_s;
    logic                  unused_wd_s;

    nios_sd_loader_pio_edge_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_edge_sync (
        .clk       (clk),
        .reset     (reset),
        .in_i      (in_port),
        .in_sync_o (in_sync_s),
        .edge_o    (edge_s)
    );

    assign wr_s        = chipselect & ~write_n;
    assign wd_s        = writedata[DATA_WIDTH-1:0];
    assign unused_wd_s = ^writedata;
    assign warm_s      = (warm_cnt_q == WARM_DONE);

    // Register-file next state; a capture on the same edge beats its W1C.
    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        w1c_s  = '0;
        if (wr_s) begin
            case (address)
                ADDR_DATA:    data_d = wd_s;
                ADDR_DIR:     dir_d  = wd_s;
                ADDR_IRQMASK: mask_d = wd_s;
                ADDR_EDGECAP: w1c_s  = wd_s;
                ADDR_OUTSET:  data_d = data_q | wd_s;
                ADDR_OUTCLR:  data_d = data_q & ~wd_s;
                default:      data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
        cap_d      = (cap_q & ~w1c_s) | (edge_s & {DATA_WIDTH{warm_s}});
        warm_cnt_d = sat_inc2(warm_cnt_q);
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            dir_q      <= RESET_DIR;
            mask_q     <= '0;
            cap_q      <= '0;
            warm_cnt_q <= 2'd0;
        end else begin
            data_q     <= data_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    // Read mux: output bits return the driven value, input bits the pin.
    always_comb begin
        case (address)
            ADDR_DATA:    readdata = 32'((dir_q & data_q) | (~dir_q & in_sync_s));
            ADDR_DIR:     readdata = 32'(dir_q);
            ADDR_IRQMASK: readdata = 32'(mask_q);
            ADDR_EDGECAP: readdata = 32'(cap_q);
            default:      readdata = 32'd0;
        endcase
    end

    assign out_port = data_q;
    assign oe       = dir_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_sd_loader_gpio_pio.sv
// Self-checking bench for nios_sd_loader_gpio_pio: directed scenarios with literal
// expectations, then randomized bus/pin traffic against a behavioural model.
module tb_nios_sd_loader_gpio_pio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  in_port = 8'h00;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios_sd_loader_gpio_pio #(
        .DATA_WIDTH  (8),
        .RESET_VALUE (8'h5A),
        .RESET_DIR   (8'hFF),
        .EDGE_TYPE   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: registers plus the pin values seen at the last three clocks.
    logic [7:0] m_data, m_dir, m_mask, m_cap;
    logic [7:0] pin_hist [3];
    int         m_clocks;
    logic [7:0] m_rise, m_wd;
    logic       m_wr;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, (m_dir & m_data) | (~m_dir & pin_hist[1])};
            3'd1:    return {24'd0, m_dir};
            3'd2:    return {24'd0, m_mask};
            3'd3:    return {24'd0, m_cap};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data = 8'h5A;
            m_dir  = 8'hFF;
            m_mask = 8'h00;
            m_cap  = 8'h00;
            for (int i = 0; i < 3; i++) pin_hist[i] = 8'h00;
            m_clocks = 0;
        end else begin
            if (m_clocks < 1000) m_clocks = m_clocks + 1;
            // A pin rising two clocks ago (low three clocks ago) is an edge now.
            m_rise = pin_hist[1] & ~pin_hist[2];
            m_wr   = chipselect & ~write_n;
            m_wd   = writedata[7:0];
            if (m_wr && address == 3'd3) m_cap = m_cap & ~m_wd;
            if (m_clocks >= 4) m_cap = m_cap | m_rise;
            if (m_wr) begin
                case (address)
                    3'd0:    m_data = m_wd;
                    3'd1:    m_dir  = m_wd;
                    3'd2:    m_mask = m_wd;
                    3'd4:    m_data = m_data | m_wd;
                    3'd5:    m_data = m_data & ~m_wd;
                    default: ;
                endcase
            end
            pin_hist[2] = pin_hist[1];
            pin_hist[1] = pin_hist[0];
            pin_hist[0] = in_port;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("model_out_port", {24'd0, out_port}, {24'd0, m_data});
            check("model_oe", {24'd0, oe}, {24'd0, m_dir});
            check("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
            check("model_readdata", readdata, model_read(address));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    endtask

    task automatic bus_idle(input logic [2:0] a);
        address = a; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    initial begin
        // Reset values
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_port", {24'd0, out_port}, 32'h5A);
        check("rst_oe", {24'd0, oe}, 32'hFF);
        check("rst_irq", {31'd0, irq}, 32'd0);
        address = 3'd2; #1;
        check("rst_rd_mask", readdata, 32'd0);
        address = 3'd3; #1;
        check("rst_rd_cap", readdata, 32'd0);

        // Set / clear
        step(); bus_wr(3'd0, 32'hFFFF_FFF0);
        step(); bus_wr(3'd4, 32'h03);
        @(negedge clk); check("setclr_F0", {24'd0, out_port}, 32'hF0);
        step(); bus_wr(3'd5, 32'h80);
        @(negedge clk); check("setclr_F3", {24'd0, out_port}, 32'hF3);
        step(); bus_idle(3'd0);
        @(negedge clk);
        check("setclr_73", {24'd0, out_port}, 32'h73);
        check("setclr_rd", readdata, 32'h73);
        check("model_pin_73", {24'd0, m_data}, 32'h73);

        // Direction mix
        step(); bus_wr(3'd1, 32'h0F);
        step(); bus_wr(3'd0, 32'hAA); in_port = 8'h53;
        step(); bus_idle(3'd0);
        step();
        @(negedge clk); check("dirmix_rd", readdata, 32'h5A);

        // Edge / IRQ
        step(); in_port = 8'h00; bus_wr(3'd2, 32'h01);
        repeat (4) step();
        bus_wr(3'd3, 32'hFF);
        step(); bus_idle(3'd3);
        step();
        @(negedge clk); check("edge_pre_irq", {31'd0, irq}, 32'd0);
        step(); in_port = 8'h01;
        step(); @(negedge clk); check("edge_k_irq", {31'd0, irq}, 32'd0);
        step(); @(negedge clk); check("edge_k1_irq", {31'd0, irq}, 32'd0);
        step(); @(negedge clk);
        check("edge_k2_irq", {31'd0, irq}, 32'd1);
        check("edge_k2_cap", readdata, 32'h01);
        step(); bus_wr(3'd3, 32'h01);
        step(); bus_idle(3'd3);
        @(negedge clk);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        check("w1c_cap", readdata, 32'h00);

        // Collision: W1C on bit0 sampled at the same edge as a new capture
        step(); in_port = 8'h00;
        repeat (4) step();
        in_port = 8'h01;
        step();
        step(); bus_wr(3'd3, 32'h01);
        step(); bus_idle(3'd3);
        @(negedge clk);
        check("collide_cap", readdata, 32'h01);
        check("collide_irq", {31'd0, irq}, 32'd1);

        // Warm-up: pins high through reset release never fire
        step(); reset = 1'b1; in_port = 8'hFF; bus_idle(3'd3);
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("warm_cap", readdata, 32'h00);
            step();
        end

        // Asynchronous reset between edges discards a pending write
        bus_wr(3'd0, 32'h11);
        #1 reset = 1'b1; bus_idle(3'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("async_rst_out", {24'd0, out_port}, 32'h5A);
        check("async_rst_model", {24'd0, m_data}, 32'h5A);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step();
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            writedata  = $urandom();
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom());
            if ($urandom_range(0, 149) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        step(); bus_idle(3'd0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
